// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and port-slice helpers for the multi-port register file
package rf_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_AW     = 5;
  localparam int ZERO_ADDR = 0;

  // Bit offset of read port k inside a packed per-port bus of element width w
  function automatic int rd_slice(input int k, input int w);
    return k * w;
  endfunction

  // Bit offset of write port j inside a packed per-port bus of element width w
  function automatic int wr_slice(input int j, input int w);
    return j * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits with set/clear priority and busy lookups
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW       = RF_AW,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  output logic [NRD-1:0]    busy
);

  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;
  logic [AW-1:0]    ra [NRD];
  logic [AW-1:0]    wa [NWR];
  logic             set_ok;

  for (genvar k = 0; k < NRD; k++) begin : g_ra
    assign ra[k] = rd_addr[rd_slice(k, AW) +: AW];
  end

  for (genvar j = 0; j < NWR; j++) begin : g_wa
    assign wa[j] = wr_addr[wr_slice(j, AW) +: AW];
  end

  assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == AW'(ZERO_ADDR)));

  // Retiring writes clear first so a same-cycle issue to that register keeps it pending
  always_comb begin
    pending_nxt = pending;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) pending_nxt[wa[j]] = 1'b0;
    end
    if (set_ok) pending_nxt[set_addr] = 1'b1;
    if (ZERO_REG != 0) pending_nxt[ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_nxt;
  end

  always_comb begin
    logic wr_hit;
    logic set_hit;
    busy = '0;
    for (int k = 0; k < NRD; k++) begin
      wr_hit = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wa[j] == ra[k])) wr_hit = 1'b1;
      end
      set_hit = set_ok && (set_addr == ra[k]);
      busy[k] = pending[ra[k]] & ~((BYPASS != 0) & wr_hit & ~set_hit);
      if ((ZERO_REG != 0) && (ra[k] == AW'(ZERO_ADDR))) busy[k] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - multi-port register file with write bypass and hazard scoreboard
module regfile_mp_scoreboard
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int AW       = RF_AW,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NRD*AW-1:0]    R_addr,
  output logic [NRD*WIDTH-1:0] R_data,
  output logic [NRD-1:0]       R_busy,
  input  logic [NWR-1:0]       W_en,
  input  logic [NWR*AW-1:0]    W_addr,
  input  logic [NWR*WIDTH-1:0] W_data,
  input  logic                 S_en,
  input  logic [AW-1:0]        S_addr,
  input  logic [AW-1:0]        dbg_addr,
  output logic [WIDTH-1:0]     dbg_data
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ra [NRD];
  logic [AW-1:0]    wa [NWR];
  logic [WIDTH-1:0] wd [NWR];
  logic [NWR-1:0]   wr_ok;

  for (genvar k = 0; k < NRD; k++) begin : g_ra
    assign ra[k] = R_addr[rd_slice(k, AW) +: AW];
  end

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wa[j]    = W_addr[wr_slice(j, AW) +: AW];
    assign wd[j]    = W_data[wr_slice(j, WIDTH) +: WIDTH];
    assign wr_ok[j] = W_en[j] && !((ZERO_REG != 0) && (wa[j] == AW'(ZERO_ADDR)));
  end

  // Later ports are applied last, so the highest index wins on address conflicts
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j]) mem[wa[j]] <= wd[j];
      end
    end
  end

  always_comb begin
    logic [WIDTH-1:0] val;
    R_data = '0;
    for (int k = 0; k < NRD; k++) begin
      val = mem[ra[k]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_ok[j] && (wa[j] == ra[k])) val = wd[j];
        end
      end
      if ((ZERO_REG != 0) && (ra[k] == AW'(ZERO_ADDR))) val = '0;
      R_data[rd_slice(k, WIDTH) +: WIDTH] = val;
    end
  end

  // Register 0 is never written when ZERO_REG=1, so the raw array read is already zero there
  assign dbg_data = mem[dbg_addr];

  rf_scoreboard #(
    .AW       (AW),
    .NRD      (NRD),
    .NWR      (NWR),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock    (clock),
    .reset_n  (reset_n),
    .rd_addr  (R_addr),
    .wr_en    (W_en),
    .wr_addr  (W_addr),
    .set_en   (S_en),
    .set_addr (S_addr),
    .busy     (R_busy)
  );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb/tb_regfile_mp_scoreboard.sv - scoreboard bench over three parameter variants of the register file
module tb_regfile_mp_scoreboard;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  ra [2];
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [1:0]  w_en;
  logic        s_en;
  logic [4:0]  s_addr;
  logic [4:0]  dbg_addr;

  logic [9:0]  r_addr_bus;
  logic [9:0]  w_addr_bus;
  logic [63:0] w_data_bus;
  logic [63:0] rdata_o [3];
  logic [1:0]  busy_o  [3];
  logic [31:0] dbg_o   [3];

  // variant 0: bypass+zero reg, 1: bypass without zero reg, 2: zero reg without bypass
  bit          byp [3] = '{1'b1, 1'b1, 1'b0};
  bit          zr  [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mmem [3][32];
  bit          mpend [3][32];
  exp_t        q [$];
  int          n_checks = 0;
  int          n_fail = 0;

  assign r_addr_bus = {ra[1], ra[0]};
  assign w_addr_bus = {wa[1], wa[0]};
  assign w_data_bus = {wd[1], wd[0]};

  always #5 clock = ~clock;

  regfile_mp_scoreboard #(.BYPASS(1), .ZERO_REG(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .R_addr(r_addr_bus), .R_data(rdata_o[0]), .R_busy(busy_o[0]),
    .W_en(w_en), .W_addr(w_addr_bus), .W_data(w_data_bus), .S_en(s_en), .S_addr(s_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_o[0]));

  regfile_mp_scoreboard #(.BYPASS(1), .ZERO_REG(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .R_addr(r_addr_bus), .R_data(rdata_o[1]), .R_busy(busy_o[1]),
    .W_en(w_en), .W_addr(w_addr_bus), .W_data(w_data_bus), .S_en(s_en), .S_addr(s_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_o[1]));

  regfile_mp_scoreboard #(.BYPASS(0), .ZERO_REG(1)) dut_c (
    .clock(clock), .reset_n(reset_n), .R_addr(r_addr_bus), .R_data(rdata_o[2]), .R_busy(busy_o[2]),
    .W_en(w_en), .W_addr(w_addr_bus), .W_data(w_data_bus), .S_en(s_en), .S_addr(s_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_o[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int v, input int k);
    logic [31:0] val;
    val = mmem[v][ra[k]];
    if (byp[v]) begin
      for (int j = 0; j < 2; j++)
        if (w_en[j] && wa[j] == ra[k] && !(zr[v] && wa[j] == 5'd0)) val = wd[j];
    end
    if (zr[v] && ra[k] == 5'd0) val = '0;
    return val;
  endfunction

  function automatic logic exp_busy(input int v, input int k);
    logic hit;
    logic sset;
    hit = 1'b0;
    for (int j = 0; j < 2; j++) if (w_en[j] && wa[j] == ra[k]) hit = 1'b1;
    sset = s_en && s_addr == ra[k] && !(zr[v] && s_addr == 5'd0);
    if (zr[v] && ra[k] == 5'd0) return 1'b0;
    return mpend[v][ra[k]] & ~(byp[v] & hit & ~sset);
  endfunction

  task automatic model_edge();
    for (int v = 0; v < 3; v++) begin
      if (!reset_n) begin
        for (int i = 0; i < 32; i++) begin
          mmem[v][i] = '0;
          mpend[v][i] = 1'b0;
        end
      end else begin
        for (int j = 0; j < 2; j++) begin
          if (w_en[j] && !(zr[v] && wa[j] == 5'd0)) mmem[v][wa[j]] = wd[j];
          if (w_en[j]) mpend[v][wa[j]] = 1'b0;
        end
        if (s_en && !(zr[v] && s_addr == 5'd0)) mpend[v][s_addr] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    w_en = '0;
    s_en = 1'b0;
  endtask

  // Expectations are queued as soon as the inputs settle, then drained against the DUT outputs
  task automatic score();
    exp_t e;
    #2;
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 2; k++) begin
        q.push_back('{$sformatf("v%0d_rd%0d", v, k), exp_rd(v, k)});
        q.push_back('{$sformatf("v%0d_busy%0d", v, k), {31'd0, exp_busy(v, k)}});
      end
      q.push_back('{$sformatf("v%0d_dbg", v), mmem[v][dbg_addr]});
    end
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 2; k++) begin
        e = q.pop_front();
        check(e.tag, rdata_o[v][k*32 +: 32], e.exp);
        e = q.pop_front();
        check(e.tag, {31'd0, busy_o[v][k]}, e.exp);
      end
      e = q.pop_front();
      check(e.tag, dbg_o[v], e.exp);
    end
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    w_en[0] = 1'b1;
    wa[0] = a;
    wd[0] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ra = '{5'd0, 5'd0};
    wa = '{5'd0, 5'd0};
    wd = '{32'd0, 32'd0};
    idle();
    s_addr = '0;
    dbg_addr = '0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    ra = '{5'd5, 5'd9};
    dbg_addr = 5'd5;
    score();
    check("rst_init_r5", rdata_o[0][31:0], 32'h0);
    wr0(5'd5, 32'hDEADBEEF);
    tick();
    idle();
    score();
    check("r5_written", dbg_o[0], 32'hDEADBEEF);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    score();
    check("rst_r5_rd", rdata_o[0][31:0], 32'h0);
    check("rst_r5_dbg", dbg_o[0], 32'h0);
    check("rst_busy", {30'd0, busy_o[0]}, 32'h0);

    ra[0] = 5'd0;
    wr0(5'd0, 32'h1234);
    score();
    check("zr_bypass_r0", rdata_o[0][31:0], 32'h0);
    check("nozr_bypass_r0", rdata_o[1][31:0], 32'h1234);
    tick();
    idle();
    score();
    check("zr_r0", rdata_o[0][31:0], 32'h0);
    check("nozr_r0", rdata_o[1][31:0], 32'h1234);

    ra[0] = 5'd7;
    wr0(5'd7, 32'h11);
    w_en[1] = 1'b1;
    wa[1] = 5'd7;
    wd[1] = 32'h22;
    score();
    check("dual_bypass", rdata_o[0][31:0], 32'h22);
    tick();
    idle();
    dbg_addr = 5'd7;
    score();
    check("dual_dbg", dbg_o[0], 32'h22);

    ra[0] = 5'd3;
    wr0(5'd3, 32'hA5A5);
    score();
    check("byp_same_cycle", rdata_o[0][31:0], 32'hA5A5);
    check("nobyp_old", rdata_o[2][31:0], 32'h0);
    tick();
    idle();
    score();
    check("nobyp_next", rdata_o[2][31:0], 32'hA5A5);

    ra[1] = 5'd9;
    s_en = 1'b1;
    s_addr = 5'd9;
    score();
    check("sb_pre", {31'd0, busy_o[0][1]}, 32'h0);
    tick();
    idle();
    score();
    check("sb_pending", {31'd0, busy_o[0][1]}, 32'h1);
    wr0(5'd9, 32'h77);
    score();
    check("sb_retire_byp", {31'd0, busy_o[0][1]}, 32'h0);
    check("sb_retire_nobyp", {31'd0, busy_o[2][1]}, 32'h1);
    tick();
    idle();
    score();
    check("sb_cleared", {31'd0, busy_o[0][1]}, 32'h0);
    s_en = 1'b1;
    wr0(5'd9, 32'h78);
    tick();
    idle();
    score();
    check("sb_set_wins", {31'd0, busy_o[0][1]}, 32'h1);
    s_en = 1'b1;
    wr0(5'd9, 32'h79);
    score();
    check("sb_reissue_busy", {31'd0, busy_o[0][1]}, 32'h1);
    tick();
    idle();

    s_en = 1'b1;
    s_addr = 5'd4;
    tick();
    s_addr = 5'd12;
    tick();
    idle();
    ra = '{5'd4, 5'd12};
    score();
    check("mid_pending", {30'd0, busy_o[0]}, 32'h3);
    reset_n = 1'b0;
    s_en = 1'b1;
    s_addr = 5'd4;
    tick();
    reset_n = 1'b1;
    idle();
    score();
    check("mid_reset_busy", {30'd0, busy_o[0]}, 32'h0);

    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 2; k++) begin
        ra[k] = 5'($urandom_range(0, 15));
        wa[k] = 5'($urandom_range(0, 15));
        wd[k] = $urandom;
      end
      w_en = 2'($urandom_range(0, 3));
      s_en = ($urandom_range(0, 3) == 0);
      s_addr = 5'($urandom_range(0, 15));
      dbg_addr = 5'($urandom_range(0, 31));
      reset_n = ($urandom_range(0, 63) != 0);
      score();
      tick();
    end
    reset_n = 1'b1;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
